// File: rtl/display_scan_if.sv
// Bundle between the counter datapath and the display scan controller:
// run/step/digit data in, count tick and digit-scan outputs back.
interface display_scan_if #(
  parameter int unsigned NUM_DIGITS = 4
) ();
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic                    run;
  logic                    step;
  logic [4*NUM_DIGITS-1:0] digit_data;
  logic                    count_tick;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic [3:0]              digit_bcd;
  logic [IDX_W-1:0]        scan_idx;
  logic                    frame_done;

  modport master (
    output run, step, digit_data,
    input  count_tick, digit_sel, digit_bcd, scan_idx, frame_done
  );

  modport slave (
    input  run, step, digit_data,
    output count_tick, digit_sel, digit_bcd, scan_idx, frame_done
  );
endinterface

// File: rtl/display_scan_controller.sv
// Time-multiplexes a seven-segment display with blanking between digits and
// produces the run/pause/single-step count-enable strobe, all on fast_clock.
module display_scan_controller #(
  parameter int unsigned SCAN_DIV     = 1024,
  parameter int unsigned BLANK_CYCLES = 64,
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned COUNT_DIV    = 16777216
) (
  input  logic           fast_clock,
  input  logic           rst,
  display_scan_if.slave  bus
);
  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
  localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
  localparam int unsigned COUNT_W = $clog2(COUNT_DIV);
  localparam int unsigned DATA_W  = 4 * NUM_DIGITS;

  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= SCAN_DIV || NUM_DIGITS < 2 || COUNT_DIV < 2)
  begin : g_param_check
    $error("display_scan_controller: illegal parameter combination");
  end

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} scan_state_t;

  scan_state_t           state_q, state_d;
  logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;
  logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic [3:0]            digit_bcd_q, digit_bcd_d;
  logic                  frame_done_q, frame_done_d;
  logic [DATA_W-1:0]     frame_q, frame_d;
  logic [COUNT_W-1:0]    count_cnt_q, count_cnt_d;
  logic                  count_tick_q, count_tick_d;
  logic [3:0]            buf_nibble;

  // Nibble of the latched frame for the current slot
  always_comb begin
    buf_nibble = 4'd0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (scan_idx_q == IDX_W'(i)) buf_nibble = frame_q[4*i +: 4];
    end
  end

  // State register
  always_ff @(posedge fast_clock or negedge rst) begin
    if (!rst) begin
      state_q      <= BLANK;
      scan_cnt_q   <= '0;
      scan_idx_q   <= '0;
      digit_sel_q  <= '0;
      digit_bcd_q  <= '0;
      frame_done_q <= 1'b0;
      frame_q      <= '0;
      count_cnt_q  <= '0;
      count_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      scan_cnt_q   <= scan_cnt_d;
      scan_idx_q   <= scan_idx_d;
      digit_sel_q  <= digit_sel_d;
      digit_bcd_q  <= digit_bcd_d;
      frame_done_q <= frame_done_d;
      frame_q      <= frame_d;
      count_cnt_q  <= count_cnt_d;
      count_tick_q <= count_tick_d;
    end
  end

  // Next-state: scan FSM plus the free-running/pausable count divider
  always_comb begin
    state_d      = state_q;
    scan_cnt_d   = scan_cnt_q + SCAN_W'(1);
    scan_idx_d   = scan_idx_q;
    digit_sel_d  = digit_sel_q;
    digit_bcd_d  = digit_bcd_q;
    frame_done_d = 1'b0;
    frame_d      = frame_q;
    count_cnt_d  = count_cnt_q;
    count_tick_d = 1'b0;

    unique case (state_q)
      BLANK: begin
        if (scan_cnt_q == SCAN_W'(BLANK_CYCLES - 1)) begin
          state_d     = SHOW;
          digit_sel_d = NUM_DIGITS'(1) << scan_idx_q;
          // Slot 0 latches the whole frame so later slots ignore mid-frame updates
          if (scan_idx_q == '0) begin
            frame_d     = bus.digit_data;
            digit_bcd_d = bus.digit_data[3:0];
          end else begin
            digit_bcd_d = buf_nibble;
          end
        end
      end
      SHOW: begin
        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
          state_d      = BLANK;
          scan_cnt_d   = '0;
          digit_sel_d  = '0;
          frame_done_d = (scan_idx_q == IDX_W'(NUM_DIGITS - 1));
          scan_idx_d   = (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0
                                                                : scan_idx_q + IDX_W'(1);
        end
      end
      default: state_d = BLANK;
    endcase

    // run has priority; step only produces a tick while paused
    if (bus.run) begin
      if (count_cnt_q == COUNT_W'(COUNT_DIV - 1)) begin
        count_cnt_d  = '0;
        count_tick_d = 1'b1;
      end else begin
        count_cnt_d = count_cnt_q + COUNT_W'(1);
      end
    end else if (bus.step) begin
      count_tick_d = 1'b1;
    end
  end

  assign bus.count_tick = count_tick_q;
  assign bus.digit_sel  = digit_sel_q;
  assign bus.digit_bcd  = digit_bcd_q;
  assign bus.scan_idx   = scan_idx_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench for display_scan_controller: per-edge expected outputs are
// queued from a timing model and compared on the following falling edge.
module tb_display_scan_controller;
  localparam int unsigned SCAN_DIV     = 16;
  localparam int unsigned BLANK_CYCLES = 4;
  localparam int unsigned NUM_DIGITS   = 4;
  localparam int unsigned COUNT_DIV    = 10;
  localparam int unsigned FRAME_LEN    = SCAN_DIV * NUM_DIGITS;

  typedef struct {
    logic [NUM_DIGITS-1:0] sel;
    logic [1:0]            idx;
    logic                  fd;
    logic                  tick;
    logic                  bcd_valid;
    logic [3:0]            bcd;
  } exp_t;

  logic fast_clock;
  logic rst;

  display_scan_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

  display_scan_controller #(
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES),
    .NUM_DIGITS  (NUM_DIGITS),
    .COUNT_DIV   (COUNT_DIV)
  ) dut (
    .fast_clock(fast_clock),
    .rst       (rst),
    .bus       (bus)
  );

  initial fast_clock = 1'b0;
  always #5 fast_clock = ~fast_clock;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  int          t;
  int          cnt_m;
  logic [15:0] frame_m;
  int          first_tick_t;
  int          last_tick_t;
  logic        prev_tick;
  int          rise_t;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  // Expected outputs after edge t, derived from slot position since reset release
  task automatic model_edge();
    exp_t e;
    int   p;
    int   slot;
    t++;
    p    = t % SCAN_DIV;
    slot = (t / SCAN_DIV) % NUM_DIGITS;
    if (p == int'(BLANK_CYCLES) && slot == 0) frame_m = bus.digit_data;
    e.sel       = (p >= int'(BLANK_CYCLES)) ? NUM_DIGITS'(1) << slot : '0;
    e.idx       = 2'(slot);
    e.fd        = (t % FRAME_LEN == 0);
    e.bcd_valid = (p >= int'(BLANK_CYCLES));
    e.bcd       = 4'(frame_m >> (4 * slot));
    e.tick      = 1'b0;
    if (bus.run) begin
      if (cnt_m == int'(COUNT_DIV) - 1) begin
        cnt_m  = 0;
        e.tick = 1'b1;
      end else begin
        cnt_m++;
      end
    end else if (bus.step) begin
      e.tick = 1'b1;
    end
    sb_q.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    check_eq("sb_depth", sb_q.size(), 1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    check_eq("digit_sel", bus.digit_sel, e.sel);
    check_eq("scan_idx", bus.scan_idx, e.idx);
    check_eq("frame_done", bus.frame_done, e.fd);
    check_eq("count_tick", bus.count_tick, e.tick);
    if (e.bcd_valid) check_eq("digit_bcd", bus.digit_bcd, e.bcd);
    check_eq("tick_back_to_back", prev_tick & bus.count_tick, 1'b0);
    prev_tick = bus.count_tick;
    if (bus.count_tick) begin
      if (first_tick_t < 0) first_tick_t = t;
      last_tick_t = t;
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge fast_clock);
      model_edge();
      @(negedge fast_clock);
      compare();
    end
  endtask

  task automatic restart_model();
    t            = 0;
    cnt_m        = 0;
    frame_m      = '0;
    first_tick_t = -1;
    last_tick_t  = -1;
    prev_tick    = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_sel"},  bus.digit_sel,  '0);
    check_eq({tag, "_bcd"},  bus.digit_bcd,  '0);
    check_eq({tag, "_idx"},  bus.scan_idx,   '0);
    check_eq({tag, "_fd"},   bus.frame_done, 1'b0);
    check_eq({tag, "_tick"}, bus.count_tick, 1'b0);
  endtask

  initial begin
    rst            = 1'b0;
    bus.run        = 1'b1;
    bus.step       = 1'b0;
    bus.digit_data = 16'h4321;
    restart_model();
    rise_t = 0;

    repeat (3) @(negedge fast_clock);
    check_all_zero("reset");
    rst = 1'b1;

    // Free run: ticks at 10, 20, 30; counter sits at 3 after t=33
    run_cycles(33);
    check_eq("first_tick", first_tick_t, 10);
    bus.run = 1'b0;

    // Pause, with a mid-frame data change during slot 2 SHOW
    run_cycles(7);
    bus.digit_data = 16'h8765;
    run_cycles(13);
    bus.step = 1'b1;
    run_cycles(1);
    bus.step = 1'b0;
    check_eq("step_tick", last_tick_t, 54);
    run_cycles(2);
    bus.run = 1'b1;
    rise_t  = t;
    run_cycles(10);
    check_eq("resume_gap", last_tick_t - rise_t, 7);

    // step while running is ignored
    bus.step = 1'b1;
    run_cycles(1);
    bus.step = 1'b0;
    run_cycles(8);

    // step and run rising together: run wins, no extra tick
    bus.run = 1'b0;
    run_cycles(3);
    bus.run  = 1'b1;
    bus.step = 1'b1;
    run_cycles(1);
    bus.step = 1'b0;
    run_cycles(90);
    check_eq("last_tick_before_reset", last_tick_t, 166);

    // Asynchronous reset during slot 2 SHOW
    check_eq("pre_reset_idx", bus.scan_idx, 2);
    #2 rst = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge fast_clock);
    @(negedge fast_clock);
    restart_model();
    rst = 1'b1;
    run_cycles(70);
    check_eq("first_tick_after_reset", first_tick_t, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
